// File: rtl/mems_write_arbiter.sv
// Round-robin arbiter that funnels NUM_CH microphone sample streams into one
// Avalon-MM write master, with one ring-buffer region and write pointer per channel.
`default_nettype none

module mems_write_arbiter #(
  parameter int          NUM_CH    = 4,
  parameter int          DATA_W    = 8,
  parameter int          BUF_DEPTH = 4096,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     ptr_clear,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [31:0]              address,
  output logic                     write,
  output logic [DATA_W-1:0]        write_data,
  input  logic                     waitrequest,
  output logic [NUM_CH-1:0]        wrap_pulse
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int GNT_W = $clog2(NUM_CH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [31:0]             addr_q, addr_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [NUM_CH-1:0]       wrap_q, wrap_d;
  logic [GNT_W-1:0]        last_q, last_d;
  logic [GNT_W-1:0]        gnt_q, gnt_d;
  logic [PTR_W-1:0]        ptr_q [NUM_CH];
  logic [PTR_W-1:0]        ptr_d [NUM_CH];

  logic                    pick_found;
  logic [GNT_W-1:0]        pick_idx;
  logic [GNT_W:0]          cand;
  logic [DATA_W-1:0]       sel_data;
  logic [PTR_W-1:0]        sel_ptr;

  // Circular search starting one past the last served channel; the extra bit in
  // cand holds last+k before it is folded back into 0..NUM_CH-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = {1'b0, last_q} + (GNT_W+1)'(k);
      if (cand >= (GNT_W+1)'(NUM_CH)) begin
        cand = cand - (GNT_W+1)'(NUM_CH);
      end
      if (!pick_found && ch_valid[cand[GNT_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[GNT_W-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_ptr  = '0;
    for (int g = 0; g < NUM_CH; g++) begin
      if (pick_idx == GNT_W'(g)) begin
        sel_data = ch_data[g*DATA_W +: DATA_W];
        sel_ptr  = ptr_q[g];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wrap_d   = '0;
    last_d   = last_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    ch_ready = '0;

    case (state_q)
      IDLE: begin
        if (enable && pick_found) begin
          for (int g = 0; g < NUM_CH; g++) begin
            ch_ready[g] = (pick_idx == GNT_W'(g));
          end
          write_d = 1'b1;
          data_d  = sel_data;
          addr_d  = BASE_ADDR + 32'(pick_idx) * 32'(BUF_DEPTH) + 32'(sel_ptr);
          gnt_d   = pick_idx;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!waitrequest) begin
          write_d = 1'b0;
          last_d  = gnt_q;
          state_d = IDLE;
          for (int g = 0; g < NUM_CH; g++) begin
            if (gnt_q == GNT_W'(g)) begin
              if (ptr_q[g] == PTR_W'(BUF_DEPTH - 1)) begin
                ptr_d[g]  = '0;
                wrap_d[g] = 1'b1;
              end else begin
                ptr_d[g]  = ptr_q[g] + 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Clearing wins over the increment; an address already latched is kept.
    if (ptr_clear) begin
      for (int g = 0; g < NUM_CH; g++) begin
        ptr_d[g] = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wrap_q  <= '0;
      last_q  <= GNT_W'(NUM_CH - 1);
      gnt_q   <= '0;
      for (int g = 0; g < NUM_CH; g++) begin
        ptr_q[g] <= '0;
      end
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wrap_q  <= wrap_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      for (int g = 0; g < NUM_CH; g++) begin
        ptr_q[g] <= ptr_d[g];
      end
    end
  end

  assign address    = addr_q;
  assign write      = write_q;
  assign write_data = data_q;
  assign wrap_pulse = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_mems_write_arbiter.sv
// Bench for mems_write_arbiter: directed scenarios then random traffic, all
// compared cycle by cycle against a transaction-level reference model.
`default_nettype none

module tb_mems_write_arbiter;

  localparam int          NUM_CH    = 4;
  localparam int          DATA_W    = 8;
  localparam int          BUF_DEPTH = 8;
  localparam logic [31:0] BASE      = 32'h0000_1000;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     enable;
  logic                     ptr_clear;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ready;
  logic [31:0]              address;
  logic                     write;
  logic [DATA_W-1:0]        write_data;
  logic                     waitrequest;
  logic [NUM_CH-1:0]        wrap_pulse;

  mems_write_arbiter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .ptr_clear(ptr_clear),
    .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .address(address), .write(write), .write_data(write_data),
    .waitrequest(waitrequest), .wrap_pulse(wrap_pulse)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one outstanding transaction plus per-channel pointers.
  bit          m_busy;
  bit          m_fresh;
  logic        m_write;
  logic [31:0] m_addr;
  logic [7:0]  m_data;
  logic [3:0]  m_wrap;
  int          m_ptr [NUM_CH];
  int          m_last;
  int          m_gnt;

  function automatic int pick();
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (m_last + k) % NUM_CH;
      if (ch_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    int         c;
    r = '0;
    c = pick();
    if (!m_busy && enable && c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_busy = 0; m_fresh = 1; m_write = 0; m_addr = 0; m_data = 0; m_wrap = 0;
      m_last = NUM_CH - 1; m_gnt = 0;
      for (int g = 0; g < NUM_CH; g++) m_ptr[g] = 0;
    end else begin
      int c;
      m_wrap = 0;
      c = pick();
      if (m_busy) begin
        if (!waitrequest) begin
          if (m_ptr[m_gnt] == BUF_DEPTH - 1) m_wrap[m_gnt] = 1'b1;
          m_ptr[m_gnt] = (m_ptr[m_gnt] + 1) % BUF_DEPTH;
          m_last  = m_gnt;
          m_busy  = 0;
          m_write = 0;
        end
      end else if (enable && c >= 0) begin
        m_busy  = 1;
        m_write = 1;
        m_fresh = 0;
        m_gnt   = c;
        m_data  = ch_data[c*DATA_W +: DATA_W];
        m_addr  = BASE + 32'(c * BUF_DEPTH + m_ptr[c]);
      end
      if (ptr_clear) begin
        for (int g = 0; g < NUM_CH; g++) m_ptr[g] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Check outputs mid-cycle, then advance one clock and update the model.
  task automatic step();
    @(negedge clock);
    chk("write", 32'(write), 32'(m_write));
    chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
    chk("ch_ready", 32'(ch_ready), 32'(exp_ready()));
    if (m_write || m_fresh) begin
      chk("address", address, m_addr);
      chk("write_data", 32'(write_data), 32'(m_data));
    end
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic until_busy();
    for (int i = 0; i < 8 && !m_busy; i++) step();
  endtask

  initial begin
    reset = 1; enable = 0; ptr_clear = 0; ch_data = '0; ch_valid = '0; waitrequest = 0;
    @(posedge clock);
    model_edge();
    #1;
    step();
    step();
    reset = 0;

    // Single channel, fixed sample: accept, write, next accept one address later.
    enable = 1; ch_valid = 4'b0001; ch_data = 32'h0000_00A5;
    repeat (6) step();

    // All channels busy: strict rotation, one write per two clocks.
    ch_valid = 4'hF;
    repeat (16) begin
      ch_data = $urandom;
      step();
    end

    // Slave stall held for five cycles in the middle of a write.
    until_busy();
    waitrequest = 1;
    repeat (5) begin
      ch_data = $urandom;
      step();
    end
    waitrequest = 0;
    repeat (4) step();

    // Lone channel 2 runs through its ring and wraps.
    ch_valid = 4'b0100;
    repeat (20) begin
      ch_data = $urandom;
      step();
    end

    // Pointer clear coinciding with channel 0 completing at its last slot.
    ch_valid = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      if (m_busy && m_ptr[0] == BUF_DEPTH - 1) begin
        ptr_clear = 1;
        step();
        ptr_clear = 0;
        break;
      end
      step();
    end
    repeat (4) step();

    // Enable dropped mid-write: current write completes, then nothing is granted.
    ch_valid = 4'hF;
    until_busy();
    enable = 0;
    repeat (6) step();
    enable = 1;
    repeat (4) step();

    // Reset while the slave stalls an active write.
    until_busy();
    waitrequest = 1;
    step();
    reset = 1;
    step();
    reset = 0; waitrequest = 0;
    repeat (6) step();

    // Random traffic.
    repeat (600) begin
      ch_valid    = 4'($urandom);
      ch_data     = $urandom;
      waitrequest = ($urandom_range(0, 3) == 0);
      enable      = ($urandom_range(0, 7) != 0);
      ptr_clear   = ($urandom_range(0, 31) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
